vga_sync_gen: RTL and testbench

//  Raster timing source for the Pong video path: free-running pixel/line counters that

---
 rtl/vga_sync_gen_pkg.sv | 20 ++
 rtl/vga_sync_gen_if.sv | 23 ++
 rtl/vga_sync_gen_axis_counter.sv | 47 ++++
 rtl/vga_sync_gen.sv | 86 ++++++++
 tb/tb_vga_sync_gen.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared timing defaults and helpers for the VGA raster generator.
// Default constants describe 640x480 @ 60 Hz with a 25.175 MHz pixel clock.
package vga_sync_gen_pkg;

  localparam int V_VISIBLE_AREA = 480;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: sync pins, blanking, line/frame strobes and position.
// The generator drives it through master; object circuits observe through slave.
interface vga_sync_gen_if #(
  parameter int CB = 10,
  parameter int RB = 10
);
  logic          o_HSync;
  logic          o_VSync;
  logic          o_HBlank;
  logic          o_VBlank;
  logic          o_HReset;
  logic          o_VReset;
  logic [CB-1:0] o_Col;
  logic [RB-1:0] o_Row;

  modport master (
    output o_HSync, o_VSync, o_HBlank, o_VBlank, o_HReset, o_VReset, o_Col, o_Row
  );

  modport slave (
    input o_HSync, o_VSync, o_HBlank, o_VBlank, o_HReset, o_VReset, o_Col, o_Row
  );
endinterface

// File: rtl/vga_sync_gen_axis_counter.sv
// One raster axis: a wrapping position counter plus blank/sync decode of its NEXT value,
// so a register fed from o_blank/o_sync lines up with o_count on the following cycle.
module vga_sync_gen_axis_counter #(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter int W       = $clog2(VISIBLE + FRONT + SYNC + BACK)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_enable,
  output logic [W-1:0] o_count,
  output logic         o_wrap,
  output logic         o_blank,
  output logic         o_sync
);
  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [W-1:0] LAST        = W'(TOTAL - 1);
  localparam logic [W-1:0] BLANK_START = W'(VISIBLE);
  localparam logic [W-1:0] SYNC_FIRST  = W'(VISIBLE + FRONT);
  localparam logic [W-1:0] SYNC_LAST   = W'(VISIBLE + FRONT + SYNC - 1);

  logic [W-1:0] count_q, count_d;

  // Wrap is an explicit compare so non-power-of-two totals never overflow naturally.
  always_comb begin
    count_d = count_q;
    if (i_enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LAST;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_wrap  = i_enable && (count_q == LAST);
  assign o_blank = (count_d >= BLANK_START);
  assign o_sync  = (count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing source: horizontal and vertical axis counters chained on the line wrap,
// with every sync/blank/strobe output registered alongside the position it describes.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int p_H_VISIBLE   = H_VISIBLE_DEF,
  parameter int p_H_FRONT     = H_FRONT_DEF,
  parameter int p_H_SYNC      = H_SYNC_DEF,
  parameter int p_H_BACK      = H_BACK_DEF,
  parameter int p_V_VISIBLE   = V_VISIBLE_AREA,
  parameter int p_V_FRONT     = V_FRONT_DEF,
  parameter int p_V_SYNC      = V_SYNC_DEF,
  parameter int p_V_BACK      = V_BACK_DEF,
  parameter bit p_SYNC_ACTIVE = 1'b0
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  vga_sync_gen_if.master  vga
);
  localparam int H_TOTAL = axis_total(p_H_VISIBLE, p_H_FRONT, p_H_SYNC, p_H_BACK);
  localparam int V_TOTAL = axis_total(p_V_VISIBLE, p_V_FRONT, p_V_SYNC, p_V_BACK);
  localparam int CB      = $clog2(H_TOTAL);
  localparam int RB      = $clog2(V_TOTAL);

  logic [CB-1:0] col;
  logic [RB-1:0] row;
  logic h_wrap, h_blank, h_sync;
  logic v_wrap, v_blank, v_sync;

  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic hblank_q, hblank_d, vblank_q, vblank_d;
  logic hreset_q, hreset_d, vreset_q, vreset_d;

  vga_sync_gen_axis_counter #(
    .VISIBLE(p_H_VISIBLE), .FRONT(p_H_FRONT), .SYNC(p_H_SYNC), .BACK(p_H_BACK), .W(CB)
  ) u_h_axis (
    .clk(i_Clk), .rst_n(i_Rst_n), .i_enable(1'b1),
    .o_count(col), .o_wrap(h_wrap), .o_blank(h_blank), .o_sync(h_sync)
  );

  // Rows advance only when the column wraps, so vertical decode changes only at col 0.
  vga_sync_gen_axis_counter #(
    .VISIBLE(p_V_VISIBLE), .FRONT(p_V_FRONT), .SYNC(p_V_SYNC), .BACK(p_V_BACK), .W(RB)
  ) u_v_axis (
    .clk(i_Clk), .rst_n(i_Rst_n), .i_enable(h_wrap),
    .o_count(row), .o_wrap(v_wrap), .o_blank(v_blank), .o_sync(v_sync)
  );

  // A wrap now means the next position is column 0 (and row 0 for the frame wrap).
  always_comb begin
    hsync_d  = h_sync ? p_SYNC_ACTIVE : ~p_SYNC_ACTIVE;
    vsync_d  = v_sync ? p_SYNC_ACTIVE : ~p_SYNC_ACTIVE;
    hblank_d = h_blank;
    vblank_d = v_blank;
    hreset_d = h_wrap;
    vreset_d = v_wrap;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hsync_q  <= ~p_SYNC_ACTIVE;
      vsync_q  <= ~p_SYNC_ACTIVE;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      hreset_q <= 1'b0;
      vreset_q <= 1'b0;
    end else begin
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      hreset_q <= hreset_d;
      vreset_q <= vreset_d;
    end
  end

  assign vga.o_HSync  = hsync_q;
  assign vga.o_VSync  = vsync_q;
  assign vga.o_HBlank = hblank_q;
  assign vga.o_VBlank = vblank_q;
  assign vga.o_HReset = hreset_q;
  assign vga.o_VReset = vreset_q;
  assign vga.o_Col    = col;
  assign vga.o_Row    = row;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a tiny-raster instance with
// active-high syncs, both checked against an arithmetic raster model via scoreboards.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic hs, vs, hb, vb, hr, vr;
  } obs_t;

  // Default timing (A) and small override timing (B), restated from the raster rules.
  localparam int AHV = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVV = 480, AVF = 10, AVS = 2, AVB = 33;
  localparam int BHV = 8, BHF = 1, BHS = 2, BHB = 1;
  localparam int BVV = 4, BVF = 1, BVS = 1, BVB = 1;
  localparam int AHT = AHV + AHF + AHS + AHB;
  localparam int AVT = AVV + AVF + AVS + AVB;
  localparam int BHT = BHV + BHF + BHS + BHB;
  localparam int BVT = BVV + BVF + BVS + BVB;

  logic clk = 1'b0;
  logic rst_a_n = 1'b1;
  logic rst_b_n = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if #(.CB($clog2(AHT)), .RB($clog2(AVT))) if_a ();
  vga_sync_gen_if #(.CB($clog2(BHT)), .RB($clog2(BVT))) if_b ();

  vga_sync_gen dut_a (.i_Clk(clk), .i_Rst_n(rst_a_n), .vga(if_a));

  vga_sync_gen #(
    .p_H_VISIBLE(BHV), .p_H_FRONT(BHF), .p_H_SYNC(BHS), .p_H_BACK(BHB),
    .p_V_VISIBLE(BVV), .p_V_FRONT(BVF), .p_V_SYNC(BVS), .p_V_BACK(BVB),
    .p_SYNC_ACTIVE(1'b1)
  ) dut_b (.i_Clk(clk), .i_Rst_n(rst_b_n), .vga(if_b));

  // Position k cycles after reset release is plain modular arithmetic on the totals.
  function automatic obs_t model(input int hv, input int hf, input int hs, input int hb,
                                 input int vv, input int vf, input int vs, input int vb,
                                 input bit act, input bit live, input int k);
    obs_t e;
    int ht, vt, c, r;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (!live) begin
      e.col = 16'(ht - 1);
      e.row = 16'(vt - 1);
      e.hb = 1'b1; e.vb = 1'b1;
      e.hs = !act; e.vs = !act;
      e.hr = 1'b0; e.vr = 1'b0;
    end else begin
      c = k % ht;
      r = (k / ht) % vt;
      e.col = 16'(c);
      e.row = 16'(r);
      e.hb = (c >= hv);
      e.vb = (r >= vv);
      e.hs = (c >= hv + hf && c < hv + hf + hs) ? act : !act;
      e.vs = (r >= vv + vf && r < vv + vf + vs) ? act : !act;
      e.hr = (c == 0);
      e.vr = (c == 0 && r == 0);
    end
    return e;
  endfunction

  task automatic check_obs(input string nm, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got col=%0d row=%0d hs=%b vs=%b hb=%b vb=%b hr=%b vr=%b | expected col=%0d row=%0d hs=%b vs=%b hb=%b vb=%b hr=%b vr=%b",
               nm, $time, got.col, got.row, got.hs, got.vs, got.hb, got.vb, got.hr, got.vr,
               exp.col, exp.row, exp.hs, exp.vs, exp.hb, exp.vb, exp.hr, exp.vr);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  function automatic obs_t sample_a();
    obs_t o;
    o.col = 16'(if_a.o_Col); o.row = 16'(if_a.o_Row);
    o.hs = if_a.o_HSync; o.vs = if_a.o_VSync; o.hb = if_a.o_HBlank; o.vb = if_a.o_VBlank;
    o.hr = if_a.o_HReset; o.vr = if_a.o_VReset;
    return o;
  endfunction

  function automatic obs_t sample_b();
    obs_t o;
    o.col = 16'(if_b.o_Col); o.row = 16'(if_b.o_Row);
    o.hs = if_b.o_HSync; o.vs = if_b.o_VSync; o.hb = if_b.o_HBlank; o.vb = if_b.o_VBlank;
    o.hr = if_b.o_HReset; o.vr = if_b.o_VReset;
    return o;
  endfunction

  obs_t q_a[$];
  obs_t q_b[$];
  event ev_a, ev_b;

  // Expectation producers: every clock edge or reset entry yields one expected sample.
  initial begin : model_a
    bit live = 1'b0;
    int k = 0;
    forever begin
      @(posedge clk or negedge rst_a_n);
      if (!rst_a_n) live = 1'b0;
      else if (!live) begin live = 1'b1; k = 0; end
      else k++;
      q_a.push_back(model(AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB, 1'b0, live, k));
      -> ev_a;
    end
  end

  initial begin : model_b
    bit live = 1'b0;
    int k = 0;
    forever begin
      @(posedge clk or negedge rst_b_n);
      if (!rst_b_n) live = 1'b0;
      else if (!live) begin live = 1'b1; k = 0; end
      else k++;
      q_b.push_back(model(BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, 1'b1, live, k));
      -> ev_b;
    end
  end

  // Monitors sample 1 time unit after each expectation and pop the scoreboard.
  initial begin : mon_a
    obs_t e, o;
    int cyc = 0, prev_hr = 0, hs_cnt = 0;
    bit prev_ok = 1'b0;
    forever begin
      @(ev_a);
      #1;
      while (q_a.size() > 0) begin
        e = q_a.pop_front();
        o = sample_a();
        check_obs("dut_a_raster", o, e);
        cyc++;
        if (!rst_a_n) begin
          prev_ok = 1'b0;
          hs_cnt = 0;
        end else begin
          if (o.hr === 1'b1) begin
            if (prev_ok) begin
              check_int("dut_a_hreset_period", cyc - prev_hr, AHT);
              check_int("dut_a_hsync_width", hs_cnt, AHS);
            end
            prev_ok = 1'b1;
            prev_hr = cyc;
            hs_cnt = 0;
          end
          if (o.hs === 1'b0) hs_cnt++;
        end
      end
    end
  end

  initial begin : mon_b
    obs_t e, o;
    int hr_cnt = 0, hr_vis = 0;
    bit frame_ok = 1'b0;
    forever begin
      @(ev_b);
      #1;
      while (q_b.size() > 0) begin
        e = q_b.pop_front();
        o = sample_b();
        check_obs("dut_b_raster", o, e);
        if (!rst_b_n) begin
          frame_ok = 1'b0;
        end else begin
          if (o.vr === 1'b1) begin
            if (frame_ok) begin
              check_int("dut_b_hresets_per_frame", hr_cnt, BVT);
              check_int("dut_b_visible_lines", hr_vis, BVV);
            end
            frame_ok = 1'b1;
            hr_cnt = 0;
            hr_vis = 0;
          end
          if (o.hr === 1'b1) begin
            hr_cnt++;
            if (o.vb === 1'b0) hr_vis++;
          end
        end
      end
    end
  end

  initial begin : stim
    #1;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    fork
      begin : stim_a
        repeat (3) @(posedge clk);
        #3 rst_a_n = 1'b1;
        // Land on col 300, row 2, then reset between edges.
        repeat (2 * AHT + 300 + 1) @(posedge clk);
        #3 rst_a_n = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #3 rst_a_n = 1'b1;
        repeat (2500) @(posedge clk);
      end
      begin : stim_b
        int n;
        repeat (3) @(posedge clk);
        #3 rst_b_n = 1'b1;
        repeat (2 * BHT * BVT + 12) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
          repeat ($urandom_range(10, 150)) @(posedge clk);
          #2 rst_b_n = 1'b0;
          n = $urandom_range(0, 3);
          repeat (n) @(posedge clk);
          #2 rst_b_n = 1'b1;
        end
        repeat (2 * BHT * BVT + 30) @(posedge clk);
      end
    join
    repeat (2) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
